// File: rtl/alarm_fsm.sv
// alarm_fsm: central control FSM of the anti-theft system.
//   in : clock, reset (async, active-high), ignition, door_driver, door_pass,
//        reprogram, expired (timer end pulse), one_hz_enable (1 s strobe)
//   out: status (LED), enable_siren, start_timer (1-cycle load pulse),
//        interval[1:0] (load parameter select), EA[2:0] (state code)
// All outputs are registered and reflect the inputs sampled at the previous edge.
module alarm_fsm (
  input  logic       clock,
  input  logic       reset,
  input  logic       ignition,
  input  logic       door_driver,
  input  logic       door_pass,
  input  logic       reprogram,
  input  logic       expired,
  input  logic       one_hz_enable,
  output logic       status,
  output logic       enable_siren,
  output logic       start_timer,
  output logic [1:0] interval,
  output logic [2:0] EA
);

  typedef enum logic [2:0] {
    ARMED      = 3'd0,
    TRIGGERED  = 3'd1,
    ALARM      = 3'd2,
    DISARMED   = 3'd3,
    WAIT_OPEN  = 3'd4,
    WAIT_CLOSE = 3'd5,
    ARM_DELAY  = 3'd6,
    ILLEGAL    = 3'd7
  } state_t;

  localparam logic [1:0] T_ARM_DELAY       = 2'b00;
  localparam logic [1:0] T_DRIVER_DELAY    = 2'b01;
  localparam logic [1:0] T_PASSENGER_DELAY = 2'b10;
  localparam logic [1:0] T_ALARM_ON        = 2'b11;

  state_t     state, nxt;
  logic       start_nxt, status_nxt;
  logic [1:0] int_nxt;
  // Timer load history: [0] is the live start pulse, [1] the cycle after it.
  // An expired pulse seen in either cycle is stale from the previous load.
  logic [1:0] ld_pipe;
  logic       honored, any_door;

  assign honored     = expired & ~|ld_pipe;
  assign any_door    = door_driver | door_pass;
  assign start_timer = ld_pipe[0];
  assign EA          = state;

  always_comb begin
    nxt       = state;
    start_nxt = 1'b0;
    int_nxt   = interval;
    if (reprogram) begin
      nxt = ARMED;
    end else begin
      case (state)
        ARMED: begin
          if (ignition) nxt = DISARMED;
          else if (door_driver) begin
            nxt = TRIGGERED; start_nxt = 1'b1; int_nxt = T_DRIVER_DELAY;
          end else if (door_pass) begin
            nxt = TRIGGERED; start_nxt = 1'b1; int_nxt = T_PASSENGER_DELAY;
          end
        end
        TRIGGERED: begin
          if (ignition) nxt = DISARMED;
          else if (honored) begin
            nxt = ALARM; start_nxt = 1'b1; int_nxt = T_ALARM_ON;
          end
        end
        ALARM: begin
          if (ignition) nxt = DISARMED;
          else if (honored && any_door) begin
            start_nxt = 1'b1; int_nxt = T_ALARM_ON;
          end else if (honored) nxt = ARMED;
        end
        DISARMED: begin
          if (!ignition) nxt = WAIT_OPEN;
        end
        WAIT_OPEN: begin
          if (ignition) nxt = DISARMED;
          else if (door_driver) nxt = WAIT_CLOSE;
        end
        WAIT_CLOSE: begin
          if (ignition) nxt = DISARMED;
          else if (!any_door) begin
            nxt = ARM_DELAY; start_nxt = 1'b1; int_nxt = T_ARM_DELAY;
          end
        end
        ARM_DELAY: begin
          if (ignition) nxt = DISARMED;
          else if (any_door) nxt = WAIT_CLOSE;
          else if (honored) nxt = ARMED;
        end
        default: nxt = ARMED;
      endcase
    end
  end

  // Blink register restarts dark on entry to ARMED, toggles while staying there.
  always_comb begin
    status_nxt = 1'b0;
    case (nxt)
      ARMED:           status_nxt = (state == ARMED) ? (status ^ one_hz_enable) : 1'b0;
      TRIGGERED, ALARM: status_nxt = 1'b1;
      default:         status_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ARMED;
      ld_pipe      <= '0;
      interval     <= T_ARM_DELAY;
      status       <= 1'b0;
      enable_siren <= 1'b0;
    end else begin
      state        <= nxt;
      ld_pipe      <= {ld_pipe[0], start_nxt};
      interval     <= int_nxt;
      status       <= status_nxt;
      enable_siren <= (nxt == ALARM);
    end
  end

endmodule

// File: tb/tb_alarm_fsm.sv
// Bench for alarm_fsm: directed walk through the main scenarios, then random
// stimulus, every cycle compared against a rule-level reference model.
module tb_alarm_fsm;
  logic clock = 1'b0, reset = 1'b1;
  logic ignition = 0, door_driver = 0, door_pass = 0, reprogram = 0, expired = 0, one_hz_enable = 0;
  logic status, enable_siren, start_timer;
  logic [1:0] interval;
  logic [2:0] EA;

  int nchk = 0, nerr = 0;

  alarm_fsm dut (
    .clock(clock), .reset(reset), .ignition(ignition), .door_driver(door_driver),
    .door_pass(door_pass), .reprogram(reprogram), .expired(expired),
    .one_hz_enable(one_hz_enable), .status(status), .enable_siren(enable_siren),
    .start_timer(start_timer), .interval(interval), .EA(EA)
  );

  always #5 clock = ~clock;

  // Reference model: state number, cycles since the last timer load,
  // strobes counted since arriving in ARMED, last load parameter.
  int m_st, m_since, m_blink, m_int;
  bit m_start;

  task automatic chk(input string tag, input int obs, input int exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_since = 100; m_blink = 0; m_int = 0; m_start = 0;
  endtask

  task automatic check_all(input string tag);
    int exp_status;
    exp_status = (m_st == 0) ? (m_blink % 2) : ((m_st == 1 || m_st == 2) ? 1 : 0);
    chk({tag, ".EA"}, int'(EA), m_st);
    chk({tag, ".status"}, int'(status), exp_status);
    chk({tag, ".siren"}, int'(enable_siren), (m_st == 2) ? 1 : 0);
    chk({tag, ".start"}, int'(start_timer), int'(m_start));
    chk({tag, ".interval"}, int'(interval), m_int);
  endtask

  // Apply one cycle of inputs, advance the model by the rules, compare.
  task automatic step(input string tag, input bit ig, dd, dp, rp, ex, hz);
    int nx; bit go; int ni; bit hon;
    ignition = ig; door_driver = dd; door_pass = dp; reprogram = rp;
    expired = ex; one_hz_enable = hz;
    hon = ex && (m_since >= 2);
    nx = m_st; go = 0; ni = m_int;
    if (rp) nx = 0;
    else if (ig && m_st != 3) nx = 3;
    else begin
      case (m_st)
        0: if (dd) begin nx = 1; go = 1; ni = 1; end
           else if (dp) begin nx = 1; go = 1; ni = 2; end
        1: if (hon) begin nx = 2; go = 1; ni = 3; end
        2: if (hon) begin
             if (dd || dp) begin go = 1; ni = 3; end else nx = 0;
           end
        3: if (!ig) nx = 4;
        4: if (dd) nx = 5;
        5: if (!dd && !dp) begin nx = 6; go = 1; ni = 0; end
        6: if (dd || dp) nx = 5; else if (hon) nx = 0;
        default: nx = 0;
      endcase
    end
    if (nx == 0) m_blink = (m_st == 0) ? m_blink + int'(hz) : 0;
    m_since = go ? 0 : ((m_since < 100) ? m_since + 1 : 100);
    m_st = nx; m_start = go; m_int = ni;
    @(posedge clock); #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit ig;
    model_reset();
    #12;
    check_all("reset");
    chk("reset.EA_const", int'(EA), 0);
    @(posedge clock); #1; reset = 0;

    // Blink in ARMED
    step("blink1", 0, 0, 0, 0, 0, 1);
    chk("blink1.on", int'(status), 1);
    idle("hold", 2);
    step("blink2", 0, 0, 0, 0, 0, 1);
    chk("blink2.off", int'(status), 0);

    // Passenger trigger, then alarm
    step("pass_trig", 0, 0, 1, 0, 0, 0);
    chk("pass_trig.int", int'(interval), 2);
    chk("pass_trig.start", int'(start_timer), 1);
    idle("trig_wait", 4);
    step("to_alarm", 0, 0, 0, 0, 1, 0);
    chk("to_alarm.EA", int'(EA), 2);
    idle("alarm_wait", 3);
    step("alarm_restart", 0, 1, 0, 0, 1, 0);
    chk("alarm_restart.start", int'(start_timer), 1);
    idle("alarm_wait2", 3);
    step("alarm_end", 0, 0, 0, 0, 1, 0);
    chk("alarm_end.EA", int'(EA), 0);

    // Disarm path through arm delay
    step("drv_trig", 0, 1, 0, 0, 0, 0);
    step("ign_on", 1, 0, 0, 0, 0, 0);
    chk("ign_on.EA", int'(EA), 3);
    step("ign_off", 0, 0, 0, 0, 0, 0);
    step("door_open", 0, 1, 0, 0, 0, 0);
    step("door_close", 0, 0, 0, 0, 0, 0);
    chk("door_close.EA", int'(EA), 6);
    step("reopen", 0, 0, 1, 0, 0, 0);
    step("close2", 0, 0, 0, 0, 0, 0);
    idle("delay", 3);
    step("arm", 0, 0, 0, 0, 1, 0);
    chk("arm.EA", int'(EA), 0);

    // Stale expired right after a load, then reprogram in ALARM
    step("trig2", 0, 0, 1, 0, 0, 0);
    step("stale", 0, 0, 0, 0, 1, 0);
    chk("stale.EA", int'(EA), 1);
    idle("w", 2);
    step("alarm2", 0, 0, 0, 0, 1, 0);
    step("reprog", 0, 1, 0, 1, 1, 0);
    chk("reprog.siren", int'(enable_siren), 0);

    // Both doors at once, then async reset mid-countdown
    step("both", 1, 1, 1, 0, 0, 0);
    step("both2", 0, 1, 1, 1, 0, 0);
    step("both3", 0, 1, 1, 0, 0, 0);
    chk("both3.int", int'(interval), 1);
    idle("mid", 2);
    #3 reset = 1; model_reset(); #1;
    check_all("async_rst");
    @(posedge clock); #1; reset = 0;
    step("post_rst_exp", 0, 0, 0, 0, 1, 0);

    // Random phase; ignition held as a slowly toggling level
    ig = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) ig = ~ig;
      step("rand", ig, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 40) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule
